// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake, control and instruction-memory write port of the loader.
interface program_loader_if #(parameter int ADDR_W = 8);
  logic              start_i;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic [ADDR_W-1:0] ins_addr_o;
  logic [31:0]       ins_data_o;
  logic              ins_wea_o;
  logic              cpu_hold_o;
  logic              done_o;
  logic              error_o;
  modport master (
    output start_i, byte_i, byte_valid_i,
    input  byte_ready_o, ins_addr_o, ins_data_o, ins_wea_o, cpu_hold_o, done_o, error_o
  );
  modport slave (
    input  start_i, byte_i, byte_valid_i,
    output byte_ready_o, ins_addr_o, ins_data_o, ins_wea_o, cpu_hold_o, done_o, error_o
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed big-endian word stream into instruction memory,
// holding the core in reset until a load completes successfully.
module program_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  program_loader_if.slave   bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;
  localparam logic [15:0] MAX_CNT = 16'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              ready_q, wea_q, hold_q, done_q, err_q;
  logic              xfer;

  assign xfer = bus.byte_valid_i & ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE, DONE, ERR: if (bus.start_i) begin
        state_d = LEN_HI;
        idx_d   = '0;
        addr_d  = '0;
      end
      LEN_HI: if (xfer) begin
        count_d = {bus.byte_i, count_q[7:0]};
        state_d = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        count_d = {count_q[15:8], bus.byte_i};
        bcnt_d  = '0;
        state_d = (count_d == 16'd0) ? DONE : (count_d > MAX_CNT) ? ERR : DATA;
      end
      DATA: if (xfer) begin
        data_d  = {data_q[23:0], bus.byte_i};
        bcnt_d  = bcnt_q + 2'd1;
        state_d = (bcnt_q == 2'd3) ? WRITE : DATA;
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        idx_d   = idx_q + 16'd1;
        state_d = (idx_d == count_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      wea_q   <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
      wea_q   <= state_d == WRITE;
      hold_q  <= state_d != DONE;
      done_q  <= state_d == DONE;
      err_q   <= state_d == ERR;
    end
  end

  assign bus.byte_ready_o = ready_q;
  assign bus.ins_addr_o   = addr_q;
  assign bus.ins_data_o   = data_q;
  assign bus.ins_wea_o    = wea_q;
  assign bus.cpu_hold_o   = hold_q;
  assign bus.done_o       = done_q;
  assign bus.error_o      = err_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized loads checked against a word-list model of the loader.
module tb_program_loader;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vecs = 0;
  int   miscompares = 0;
  int   wa[$];
  logic [31:0] wd[$];
  int   wc[$];
  int   xc[$];
  int   done_cyc = -1;

  program_loader_if #(.ADDR_W(8)) bus ();
  program_loader #(.DEPTH(DEPTH), .ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.ins_wea_o) begin
      wa.push_back(int'(bus.ins_addr_o));
      wd.push_back(bus.ins_data_o);
      wc.push_back(cyc);
    end
    if (bus.done_o && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wa.delete();
    wd.delete();
    wc.delete();
    done_cyc = -1;
  endtask

  task automatic stream(input logic [7:0] b[$], input int gap, input bit pat, input bit poke);
    int i;
    int t;
    bit v;
    logic [6:0] vp;
    vp = 7'b1101001;
    i = 0;
    t = 0;
    xc.delete();
    while (i < b.size() && t < 3000) begin
      @(negedge clk);
      v = pat ? vp[t % 7] : ($urandom_range(99) >= gap);
      bus.byte_valid_i = v;
      bus.byte_i = v ? b[i] : 8'($urandom);
      bus.start_i = poke && i == 4;
      if (v && bus.byte_ready_o) begin
        xc.push_back(cyc + 1);
        i++;
      end
      t++;
    end
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    bus.start_i = 1'b0;
    chk("stream_bound", 32'(i), 32'(b.size()));
  endtask

  // Model: the count decides the outcome; a legal load writes word k to address k,
  // one cycle after the transfer of that word's last byte.
  task automatic load(input int n, input logic [31:0] fw[$], input int gap, input bit pat, input bit poke);
    logic [15:0] c;
    logic [7:0]  b[$];
    logic [31:0] w[$];
    logic [31:0] x;
    bit bad;
    int nw;
    c = 16'(n);
    bad = n > DEPTH;
    nw = bad ? 0 : n;
    b.push_back(c[15:8]);
    b.push_back(c[7:0]);
    for (int k = 0; k < nw; k++) begin
      x = (k < fw.size()) ? fw[k] : $urandom;
      w.push_back(x);
      b.push_back(x[31:24]);
      b.push_back(x[23:16]);
      b.push_back(x[15:8]);
      b.push_back(x[7:0]);
    end
    pulse_start();
    stream(b, gap, pat, poke);
    for (int k = 0; k < 40 && !(bus.done_o || bus.error_o); k++) @(negedge clk);
    chk("done", 32'(bus.done_o), 32'(!bad));
    chk("error", 32'(bus.error_o), 32'(bad));
    chk("cpu_hold", 32'(bus.cpu_hold_o), 32'(bad));
    chk("ready_idle", 32'(bus.byte_ready_o), 32'd0);
    chk("n_writes", 32'(wa.size()), 32'(nw));
    for (int k = 0; k < nw && k < wa.size(); k++) begin
      chk($sformatf("wr_addr%0d", k), 32'(wa[k]), 32'(k % 256));
      chk($sformatf("wr_data%0d", k), wd[k], w[k]);
      chk($sformatf("wr_cycle%0d", k), 32'(wc[k]), 32'(xc[2 + 4 * k + 3]));
    end
    if (!bad && gap == 0 && !pat) chk("latency", 32'(done_cyc - xc[0]), 32'(2 + 5 * n - 1));
  endtask

  initial begin
    logic [31:0] none[$];
    logic [31:0] fw[$];
    logic [7:0]  b[$];
    int n;
    bus.start_i = 1'b0;
    bus.byte_i = 8'h00;
    bus.byte_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(bus.cpu_hold_o), 32'd1);
    chk("rst_ready", 32'(bus.byte_ready_o), 32'd0);
    chk("rst_addr", 32'(bus.ins_addr_o), 32'd0);
    chk("rst_data", bus.ins_data_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 32'(bus.cpu_hold_o), 32'd1);
    chk("idle_done", 32'(bus.done_o), 32'd0);
    chk("idle_error", 32'(bus.error_o), 32'd0);
    chk("idle_ready", 32'(bus.byte_ready_o), 32'd0);
    chk("idle_wea", 32'(bus.ins_wea_o), 32'd0);
    pulse_start();
    chk("start_ready", 32'(bus.byte_ready_o), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    fw = '{32'h12345678, 32'h9ABCDEF0};
    load(2, fw, 0, 1'b0, 1'b0);
    load(0, none, 0, 1'b0, 1'b0);
    load(257, none, 0, 1'b0, 1'b0);
    fw = '{32'hAABBCCDD};
    load(1, fw, 0, 1'b0, 1'b0);
    load(1, none, 0, 1'b1, 1'b1);

    pulse_start();
    b = '{8'h00, 8'h03, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    stream(b, 0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && wa.size() == 0; k++) @(negedge clk);
    chk("pre_reset_writes", 32'(wa.size()), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hold", 32'(bus.cpu_hold_o), 32'd1);
    chk("midrst_ready", 32'(bus.byte_ready_o), 32'd0);
    chk("midrst_addr", 32'(bus.ins_addr_o), 32'd0);
    chk("midrst_wea", 32'(bus.ins_wea_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load(1, none, 0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(9);
      n = (n < 6) ? n : (n < 8) ? int'($urandom_range(300, 257)) : 65535;
      load(n, none, ($urandom_range(1) == 1) ? 40 : 0, 1'b0, 1'b0);
    end
    load(DEPTH, none, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
